// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: reset PC, instruction width,
// PC increment, the canonical NOP and the FIFO entry layout.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [31:0]            pc;
  } fetch_entry_t;

  localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] adr);
    return {adr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_instr_fifo.sv
// Synchronous FIFO holding fetched instructions. Flush empties it in one
// cycle; push/pop against full/empty are ignored.
module instr_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = ENTRY_WIDTH,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] CAP = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CAP);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are meaningless while empty so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads,
// buffers responses with their PC and hands them to decode over valid/ready.
// A redirect flushes the buffer and drops every response still in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_adr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_npc
);

  localparam int          CW  = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_use;
  logic          fifo_empty;
  logic          fifo_full;
  logic          accept;
  logic          rsp;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Credits count both requests in flight and entries waiting, so a response
  // always finds room in the FIFO. Only registered state feeds the request.
  assign in_use   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req = !reset && !redirect && (in_use < CAP);
  assign imem_adr = fetch_pc;

  assign accept = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp    = imem_rvalid && (outstanding != '0);
  assign push   = rsp && (discard == '0) && !redirect;
  assign pop    = instr_valid && instr_ready && !redirect;

  assign push_entry = '{instr: imem_rdata, pc: resp_pc};

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc    : '0;
  assign instr_npc   = instr_pc + PC_STEP;

  // Fetch/response PCs and the in-flight / to-be-dropped counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= word_align(RESET_PC);
      resp_pc     <= word_align(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      // Every response not yet returned belongs to the old path; the one
      // arriving this cycle is already dropped by suppressing the push.
      fetch_pc    <= word_align(redirect_pc);
      resp_pc     <= word_align(redirect_pc);
      outstanding <= outstanding - CW'(rsp);
      discard     <= outstanding - CW'(rsp);
    end else begin
      if (accept) fetch_pc <= fetch_pc + PC_STEP;
      if (push)   resp_pc  <= resp_pc + PC_STEP;
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (rsp && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  instr_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (outstanding == '0)));

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model
// of programmable latency.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_adr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_npc;

  int          total;
  int          bad;
  logic [31:0] exp_pc;
  int          lat;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_adr    (imem_adr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_npc   (instr_npc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a bijective pattern so stale words are recognisable.
  function automatic logic [31:0] mem_word(input logic [31:0] adr);
    return INSTR_NOP ^ ~adr;
  endfunction

  // In-order memory: each grant returns `lat` cycles later, one per cycle.
  logic [31:0] q_adr [16];
  int          q_due [16];
  logic [3:0]  q_wr;
  logic [3:0]  q_rd;
  int          mcyc;

  assign imem_rvalid = (q_rd != q_wr) && (q_due[q_rd] <= mcyc);
  assign imem_rdata  = imem_rvalid ? mem_word(q_adr[q_rd]) : 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q_wr <= '0;
      q_rd <= '0;
      mcyc <= 0;
    end else begin
      mcyc <= mcyc + 1;
      if (imem_rvalid) q_rd <= q_rd + 4'd1;
      if (imem_req && imem_gnt) begin
        q_adr[q_wr] <= imem_adr;
        q_due[q_wr] <= mcyc + lat;
        q_wr        <= q_wr + 4'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  // Compare the FIFO head with the expected stream; advance on a pop.
  task automatic check_head(input logic want_valid);
    check1("instr_valid", instr_valid, want_valid);
    if (want_valid && instr_valid) begin
      check("instr_pc", instr_pc, exp_pc);
      check("instr", instr, mem_word(exp_pc));
      check("instr_npc", instr_npc, exp_pc + 32'd4);
      if (instr_ready && !redirect) exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, input string tag);
    int n;
    n = 0;
    while (!instr_valid && n < limit) begin
      step();
      n++;
    end
    check1(tag, instr_valid, 1'b1);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (instr_valid) check_head(1'b1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check1({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_adr"}, imem_adr, 32'h0);
    check1({tag, "_vld"}, instr_valid, 1'b0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_pc"}, instr_pc, 32'h0);
    check({tag, "_npc"}, instr_npc, 32'h4);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    lat         = 1;
    exp_pc      = 32'h0;
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;

    step();
    check_reset_vals("rst");

    // Streaming: grant every cycle, 1-cycle memory, decoder always ready.
    @(negedge clk);
    reset       = 1'b0;
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    #1;
    check1("c0_req", imem_req, 1'b1);
    check("c0_adr", imem_adr, 32'h0);
    check_head(1'b0);
    step();
    check_head(1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_head(1'b1);
    end

    // Back-pressure: FIFO fills to 4 and the request drops.
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    check_head(1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_head(1'b1);
    end
    check1("full_req", imem_req, 1'b0);
    @(negedge clk);
    imem_gnt    = 1'b0;
    instr_ready = 1'b1;
    #1;
    check_head(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_head(1'b1);
    end
    step();
    check_head(1'b0);

    // Grant withheld: request and address hold, then one fetch is accepted.
    for (int i = 0; i < 3; i++) begin
      step();
      check1("hold_req", imem_req, 1'b1);
      check("hold_adr", imem_adr, exp_pc);
    end
    @(negedge clk);
    imem_gnt = 1'b1;
    #1;
    check1("gnt_req", imem_req, 1'b1);
    check("gnt_adr", imem_adr, exp_pc);
    @(negedge clk);
    imem_gnt = 1'b0;
    #1;
    check("after_gnt_adr", imem_adr, exp_pc + 32'd4);
    check_head(1'b0);
    step();
    check_head(1'b1);
    step();
    check_head(1'b0);

    // Redirect with two responses outstanding on a 3-cycle memory.
    @(negedge clk);
    lat      = 3;
    imem_gnt = 1'b1;
    #1;
    check_head(1'b0);
    step();
    check_head(1'b0);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check1("redir_req", imem_req, 1'b0);
    check1("redir_rvalid", imem_rvalid, 1'b0);
    exp_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check1("r1_req", imem_req, 1'b1);
    check("r1_adr", imem_adr, 32'h0000_0100);
    check_head(1'b0);
    wait_valid(12, "redir_wait");
    check_head(1'b1);
    @(negedge clk);
    lat = 1;
    #1;
    if (instr_valid) check_head(1'b1);
    stream(12);

    // Redirect in a cycle with a response arriving and a decoder pop.
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    check1("coinc_rvalid", imem_rvalid, 1'b1);
    check1("coinc_vld", instr_valid, 1'b1);
    exp_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check_head(1'b0);
    step();
    check_head(1'b0);
    step();
    check_head(1'b1);
    stream(4);

    // PC wrap at the top of the address space.
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    #1;
    exp_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    wait_valid(6, "wrap_wait");
    check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    check_head(1'b1);
    step();
    check("wrap_npc", instr_npc, 32'h0000_0000);
    check_head(1'b1);
    step();
    check("wrap_pc2", instr_pc, 32'h0000_0000);
    check_head(1'b1);

    // Asynchronous reset mid-stream.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. Owns the architectural fetch PC, issues in-order word reads to instruction memory, and buffers returned instructions with their PC and PC+4 in a small FIFO. Delivers them to decode over a valid/ready handshake. Accepts a redirect (branch/jump target) that flushes everything in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, instruction FIFO entries; power of two, ≥2; also the cap on outstanding-plus-buffered requests

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_req  out  1  fetch request valid
- imem_adr  out  32  word address of request, bits [1:0] always 0
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data returned (in order, ≥1 cycle after grant)
- imem_rdata  in  32  instruction word
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- instr_valid  out  1  instr/instr_pc/instr_npc valid
- instr_ready  in  1  decoder consumes entry
- instr  out  32  instruction word
- instr_pc  out  32  its address
- instr_npc  out  32  instr_pc + 4 (mod 2^32)

## Operation
- State: fetch_pc, resp_pc (32b each), outstanding count, discard count, FIFO of {rdata, pc}.
- Credit rule: imem_req = !redirect && (outstanding + fifo_count < DEPTH), from registered values only; never combinationally from imem_gnt.
- imem_adr = fetch_pc. Request accepted when imem_req && imem_gnt: fetch_pc += 4, outstanding++.
- Once asserted, imem_req/imem_adr hold stable until granted, except on redirect.
- Response (imem_rvalid): outstanding--. If discard > 0: discard--, data dropped. Otherwise push {imem_rdata, resp_pc}, resp_pc += 4.
- Output: instr_valid = FIFO non-empty; head presented; pop on instr_valid && instr_ready. instr_npc computed from head pc.
- Redirect (highest priority): FIFO cleared; fetch_pc and resp_pc ← {redirect_pc[31:2], 2'b00}; discard ← outstanding − (imem_rvalid ? 1 : 0) + discard adjustment (responses still due all dropped, including any arriving in the redirect cycle); no request that cycle; a pop in the same cycle has no effect beyond the flush.
- Simultaneous push and pop: count unchanged; credit rule guarantees push never hits a full FIFO.
- imem_rvalid with outstanding == 0 is a protocol error (assertion), ignored by RTL.
- PC wraps 32'hFFFF_FFFC → 0 with no flag.

## Timing
- Reset values: imem_req 0 during reset, imem_adr = RESET_PC, instr_valid 0, instr/instr_pc 0, instr_npc 4, counts 0.
- First edge after reset release: imem_req = 1 in cycle 0.
- Latency: grant in cycle N, rvalid in N+1 → instr_valid in N+2 (FIFO registered; no bypass).
- Throughput: with DEPTH = 4, 1-cycle memory and instr_ready held high, one instruction per cycle sustained.
- Redirect in cycle R: first request to new target in R+1; no stale instruction visible from R+1 on.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; in-flight responses after reset are the memory's responsibility (must be quiesced by the same reset).

## Structure
- Shared cpu package: RESET_PC default, INSTR_WIDTH = 32, PC_STEP = 4, INSTR_NOP = 32'h0000_0013 (for bench fill).
- One sub-module: instr_fifo (synchronous FIFO, width 64, depth DEPTH, flush input, count output, async active-high reset).
- Counters sized $clog2(DEPTH)+1 bits.

## Test plan
- Reset release, memory grants every cycle with 1-cycle latency, instr_ready=1 → instr_pc sequence 0,4,8,… one per cycle from cycle 2; instr_npc = pc+4.
- instr_ready=0 for 10 cycles → imem_req drops once outstanding+count = 4; exactly 4 entries queued; release resumes in order with no gaps or duplicates.
- imem_gnt low 3 cycles → imem_req and imem_adr stable throughout, then single accepted fetch.
- Redirect to 32'h0000_0103 with 2 responses outstanding → both dropped, next instr_pc = 32'h0000_0100, FIFO empty in cycle R+1.
- Redirect coinciding with imem_rvalid and a decoder pop → that response dropped, no spurious instr_valid.
- Fetch from 32'hFFFF_FFF8 → instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_npc of FFFF_FFFC is 0.
